// File: rtl/bin_to_oh_stream.sv
// bin_to_oh_stream: valid/ready binary-index to one-hot decoder with 2-entry skid buffer; BIN_TO_OH_ERR_CNT_EN adds the out-of-range counter.
module bin_to_oh_stream #(
  parameter int OUT_WIDTH = 3,
  parameter int CNT_WIDTH = 8,
  localparam int IDX_WIDTH = $clog2(OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_WIDTH-1:0] in_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_oh,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] err_cnt
);
  localparam logic [IDX_WIDTH:0] LIMIT = (IDX_WIDTH+1)'(OUT_WIDTH);
  logic                 skid_valid;
  logic [OUT_WIDTH-1:0] skid_oh;
  logic                 skid_err;
  logic [OUT_WIDTH-1:0] dec_oh;
  logic                 dec_err;
  logic                 in_fire;
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;
  always_comb begin
    dec_err = {1'b0, in_idx} >= LIMIT;
    dec_oh  = dec_err ? '0 : OUT_WIDTH'(1) << in_idx;
  end
  // Main register refills from skid first so ordering stays FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_oh     <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_oh    <= '0;
      skid_err   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_oh     <= skid_oh;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_oh  <= dec_oh;
          out_err <= dec_err;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_oh    <= dec_oh;
      skid_err   <= dec_err;
    end
  end
`ifdef BIN_TO_OH_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (err_clr) err_cnt <= CNT_WIDTH'(in_fire & dec_err);
    else if (in_fire && dec_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_bin_to_oh_stream.sv
// tb_bin_to_oh_stream: scoreboard bench for bin_to_oh_stream (OUT_WIDTH=3, CNT_WIDTH=4).
module tb_bin_to_oh_stream;
  localparam int OW = 3;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_oh;
  logic          out_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_cnt;
  int            passed = 0;
  int            total = 0;
  int            exp_cnt = 0;
  logic [OW:0]   q[$];

  bin_to_oh_stream #(.OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_oh(out_oh), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [OW:0] model(input logic [1:0] idx);
    return (idx >= OW) ? {{OW{1'b0}}, 1'b1} : {OW'(1) << idx, 1'b0};
  endfunction

  task automatic cnt_chk(input string name);
`ifdef BIN_TO_OH_ERR_CNT_EN
    chk(name, 32'(err_cnt), 32'(exp_cnt));
`else
    chk(name, 32'(err_cnt), 32'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic rdy, input logic clr);
    logic [OW:0] e;
    in_valid = v; in_idx = idx; out_ready = rdy; err_clr = clr;
    e = model(idx);
    if (clr) exp_cnt = (v && in_ready && e[0]) ? 1 : 0;
    else if (v && in_ready && e[0] && exp_cnt != 15) exp_cnt++;
    if (v && in_ready) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", {out_oh, out_err}, 32'hFFFF);
      else chk("scoreboard_out", {out_oh, out_err}, q.pop_front());
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_oh", 32'(out_oh), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    cnt_chk("rst_err_cnt");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 0, 1, 0); chk("b2b_in_ready0", 32'(in_ready), 1);
    chk("latency_valid", 32'(out_valid), 1);
    drive(1, 1, 1, 0); chk("b2b_in_ready1", 32'(in_ready), 1);
    drive(1, 2, 1, 0); chk("b2b_in_ready2", 32'(in_ready), 1);
    drive(0, 0, 1, 0);
    drive(1, 3, 1, 0); cnt_chk("oor_cnt1");
    chk("oor_err", 32'(out_err), 1);
    drive(1, 3, 1, 1); cnt_chk("clr_with_err");
    drive(0, 0, 1, 1); cnt_chk("clr_alone");
    drive(1, 1, 0, 0); chk("stall_in_ready", 32'(in_ready), 1);
    drive(1, 2, 0, 0); chk("skid_full", 32'(in_ready), 0);
    drive(1, 0, 0, 0); chk("held_oh", 32'(out_oh), 32'b010);
    chk("held_valid", 32'(out_valid), 1);
    drive(0, 0, 1, 0); chk("skid_drained", 32'(in_ready), 1);
    chk("skid_to_main", 32'(out_oh), 32'b100);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 3, 1, 0);
      if (i == 13) cnt_chk("sat_14");
    end
    cnt_chk("sat_15");
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 3, 0, 0);
    chk("pre_rst_full", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    exp_cnt = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_oh", 32'(out_oh), 0);
    chk("mid_rst_err", 32'(out_err), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    cnt_chk("mid_rst_cnt");
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1, 0, 1, 0); chk("post_rst_oh", 32'(out_oh), 32'b001);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    chk("post_rst_idle", 32'(out_valid), 0);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
